mem_access_stage: RTL

//   Parametrised MEM pipeline stage for the 16-bit pipelined processor, sitting between EX/MEM and
//   MEM/WB. Drives a request/grant/rvalid data-memory port with variable latency and stalls

---
 rtl/mem_access_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: request/grant/rvalid data-memory port, branch/jump resolution, MEM/WB register.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IMM_WIDTH  = 8,
  parameter int REG_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  MemSrc_i,
  input  logic [IMM_WIDTH-1:0]  imm_i,
  input  logic [DATA_WIDTH-1:0] floating_Result_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  jumpM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MovM_i,
  input  logic                  FloatingM_i,
  input  logic                  stall_MEM_WB_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  input  logic                  dm_gnt_i,
  input  logic                  dm_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  output logic                  busy_o,
  output logic                  PC_src_o,
  output logic                  jumpM_o,
  output logic [ADDR_WIDTH-1:0] target_o,
  output logic [DATA_WIDTH-1:0] WBResultM_w,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic [REG_WIDTH-1:0]  WriteRegM_o,
  output logic                  RegWriteM_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] sd;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic acc, is_load, is_store;
  logic requesting, complete, timeout;

  assign sd       = MemSrc_i ? ResultW_i : WriteDataM_i;
  assign acc      = valid_i & (MemReadM_i | MemWriteM_i);
  assign is_store = valid_i & MemWriteM_i;
  assign is_load  = valid_i & MemReadM_i & ~MemWriteM_i;

  assign dm_addr_o  = ADDR_WIDTH'(imm_i);
  assign dm_wdata_o = sd;
  assign dm_req_o   = requesting;
  assign dm_we_o    = requesting & MemWriteM_i;

  assign WBResultM_w = MovM_i      ? DATA_WIDTH'($signed(imm_i)) :
                       FloatingM_i ? floating_Result_i : alu_outM_i;

  // Control flow resolves independently of any outstanding memory access.
  assign PC_src_o = valid_i & BranchM_i & (sd == {DATA_WIDTH{1'b0}});
  assign jumpM_o  = valid_i & jumpM_i;
  assign target_o = ADDR_WIDTH'(imm_i);

  // HOLD retires as soon as the stall lifts; otherwise busy until an unstalled completion.
  assign busy_o = (state == HOLD) ? stall_MEM_WB_i
                                  : (acc & ~((complete | timeout) & ~stall_MEM_WB_i));

  // Request and completion decode for the current state.
  always_comb begin
    requesting = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        requesting = acc;
        complete   = acc & dm_gnt_i & (is_store | dm_rvalid_i);
      end
      REQ: begin
        requesting = 1'b1;
        complete   = acc & dm_gnt_i & (is_store | dm_rvalid_i);
      end
      WAIT: begin
        requesting = 1'b0;
        complete   = dm_rvalid_i;
      end
      HOLD: begin
        requesting = 1'b0;
        complete   = 1'b0;
      end
      default: begin
        requesting = 1'b0;
        complete   = 1'b0;
      end
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else if (complete) begin
      state_next = stall_MEM_WB_i ? HOLD : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (acc & dm_gnt_i) begin
            state_next = WAIT;
          end else if (acc) begin
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
        REQ: begin
          if (~acc) begin
            state_next = IDLE;
          end else if (dm_gnt_i) begin
            state_next = WAIT;
          end else begin
            state_next = REQ;
          end
        end
        WAIT:    state_next = WAIT;
        HOLD:    state_next = stall_MEM_WB_i ? HOLD : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic in_access, stay_access;

  assign in_access   = (state == REQ) | (state == WAIT);
  assign stay_access = (state_next == REQ) | (state_next == WAIT);
  // Abort only when MEM/WB can take the failed instruction this cycle.
  assign timeout = in_access & ~complete & ~stall_MEM_WB_i & (cnt == CNT_W'(TIMEOUT - 1));

  // Watchdog: counts cycles spent in REQ/WAIT, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (in_access & stay_access) begin
      cnt <= (cnt == CNT_W'(TIMEOUT - 1)) ? cnt : cnt + CNT_W'(1);
    end else begin
      cnt <= {CNT_W{1'b0}};
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Late load data captured while MEM/WB is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (complete & stall_MEM_WB_i & is_load) begin
      rdata_q <= dm_rdata_i;
    end
  end

  // MEM/WB pipeline register with the fully muxed writeback value.
  always_ff @(posedge clk) begin
    if (rst) begin
      WBResultM_o <= {DATA_WIDTH{1'b0}};
      WriteRegM_o <= {REG_WIDTH{1'b0}};
      RegWriteM_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= timeout;
      if (stall_MEM_WB_i) begin
        WBResultM_o <= WBResultM_o;
        WriteRegM_o <= WriteRegM_o;
        RegWriteM_o <= RegWriteM_o;
      end else if (timeout) begin
        WBResultM_o <= {DATA_WIDTH{1'b0}};
        WriteRegM_o <= WriteRegM_i;
        RegWriteM_o <= 1'b0;
      end else if (busy_o) begin
        RegWriteM_o <= 1'b0;
      end else begin
        WriteRegM_o <= WriteRegM_i;
        RegWriteM_o <= valid_i & RegWriteM_i;
        if (is_load) begin
          WBResultM_o <= (state == HOLD) ? rdata_q : dm_rdata_i;
        end else begin
          WBResultM_o <= WBResultM_w;
        end
      end
    end
  end

endmodule
